// File: rtl/nfu_pkg.sv
// Shared definitions for the NFU-3 coefficient path: loader FSM encoding and table geometry defaults.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package nfu_pkg;

    // Default width of one coefficient half (ai or bi).
    localparam int NFU_BIT_WIDTH_DEF = 16;

    // Default number of piecewise-sigmoid segments in one table.
    localparam int NFU_NUM_SEG_DEF = 16;

    // Coefficient loader FSM encoding.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_GET_A = 3'd1,
        ST_GET_B = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } nfu3_ld_state_t;

    // Address width for a table of n segments; never below one bit.
    function automatic int nfu_addr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/nfu3_coef_loader.sv
// Streams ai/bi word pairs into the NFU-3 coefficient RAM, one {ai,bi} write per segment, then pulses done.
// Latency: first write strobe 3 edges after start is sampled; done 3*NUM_SEG+1 edges after start (valid held high).
// Backpressure: o_coef_ready only in GET_A/GET_B; the FSM holds while i_coef_valid is low. Optional checksum: NFU3_COEF_LOADER_CHECKSUM_EN.
module nfu3_coef_loader
    import nfu_pkg::*;
#(
    parameter int BIT_WIDTH = NFU_BIT_WIDTH_DEF,
    parameter int NUM_SEG   = NFU_NUM_SEG_DEF,
    parameter int AW        = nfu_addr_w(NUM_SEG)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_start,
    input  logic [BIT_WIDTH-1:0]   i_coef_data,
    input  logic                   i_coef_valid,
    output logic                   o_coef_ready,
    output logic [2*BIT_WIDTH-1:0] o_coef,
    output logic [AW-1:0]          o_coef_addr,
    output logic                   o_load_coef,
    output logic                   o_busy,
    output logic                   o_done,
    output logic [BIT_WIDTH-1:0]   o_checksum
);

    // Segment index of the final write; the counter stops here instead of wrapping.
    localparam logic [AW-1:0] LAST_SEG = AW'(NUM_SEG - 1);

    nfu3_ld_state_t         r_state;
    logic [AW-1:0]          r_seg_cnt;
    logic [BIT_WIDTH-1:0]   r_ai;
    logic [2*BIT_WIDTH-1:0] r_coef;
    logic [AW-1:0]          r_coef_addr;
    logic                   r_load_coef;
    logic                   r_coef_ready;
    logic                   r_busy;
    logic                   r_done;

    // A word moves only when the loader is asking for one and the source offers one.
    logic w_accept;
    // Start is honoured only from IDLE so a running load is never restarted.
    logic w_start_load;

    assign w_accept     = i_coef_valid & r_coef_ready;
    assign w_start_load = (r_state == ST_IDLE) & i_start;

    // Loader FSM; every output is registered alongside the state it belongs to.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_seg_cnt    <= '0;
            r_ai         <= '0;
            r_coef       <= '0;
            r_coef_addr  <= '0;
            r_load_coef  <= 1'b0;
            r_coef_ready <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            // Strobes are single-cycle unless re-armed below.
            r_load_coef <= 1'b0;
            r_done      <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_start_load) begin
                        r_state      <= ST_GET_A;
                        r_seg_cnt    <= '0;
                        r_coef_ready <= 1'b1;
                        r_busy       <= 1'b1;
                    end
                end
                ST_GET_A: begin
                    if (w_accept) begin
                        r_ai    <= i_coef_data;
                        r_state <= ST_GET_B;
                    end
                end
                ST_GET_B: begin
                    // bi goes straight into the low half of the write line; the line then holds
                    // until the next write, so consumers only need o_load_coef to qualify it.
                    if (w_accept) begin
                        r_coef       <= {r_ai, i_coef_data};
                        r_coef_addr  <= r_seg_cnt;
                        r_load_coef  <= 1'b1;
                        r_coef_ready <= 1'b0;
                        r_state      <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (r_seg_cnt == LAST_SEG) begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_seg_cnt    <= r_seg_cnt + 1'b1;
                        r_coef_ready <= 1'b1;
                        r_state      <= ST_GET_A;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_coef_ready <= 1'b0;
                    r_busy       <= 1'b0;
                end
            endcase
        end
    end

    assign o_coef_ready = r_coef_ready;
    assign o_coef       = r_coef;
    assign o_coef_addr  = r_coef_addr;
    assign o_load_coef  = r_load_coef;
    assign o_busy       = r_busy;
    assign o_done       = r_done;

`ifdef NFU3_COEF_LOADER_CHECKSUM_EN
    logic [BIT_WIDTH-1:0] r_checksum;

    // Running modulo-2^BIT_WIDTH sum of accepted words, cleared when a load starts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_checksum <= '0;
        end else if (w_start_load) begin
            r_checksum <= '0;
        end else if (w_accept) begin
            r_checksum <= r_checksum + i_coef_data;
        end
    end

    assign o_checksum = r_checksum;
`else
    assign o_checksum = '0;
`endif

endmodule

// File: tb/tb_nfu3_coef_loader.sv
// Directed bench for nfu3_coef_loader: contiguous load, stall, ignored restart, mid-load reset, checksum.
// Timing: strobes are indexed by the edge that captures them, counting the start-sampling edge as 0.
// Backpressure: the word driver only advances on cycles where ready was high before the edge.
module tb_nfu3_coef_loader;

    localparam int BW = 16;
    localparam int NS = 16;
    localparam int AW = 4;

    logic            clk;
    logic            rst;
    logic            i_start;
    logic [BW-1:0]   i_coef_data;
    logic            i_coef_valid;
    logic            o_coef_ready;
    logic [2*BW-1:0] o_coef;
    logic [AW-1:0]   o_coef_addr;
    logic            o_load_coef;
    logic            o_busy;
    logic            o_done;
    logic [BW-1:0]   o_checksum;

    nfu3_coef_loader #(.BIT_WIDTH(BW), .NUM_SEG(NS)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_start      (i_start),
        .i_coef_data  (i_coef_data),
        .i_coef_valid (i_coef_valid),
        .o_coef_ready (o_coef_ready),
        .o_coef       (o_coef),
        .o_coef_addr  (o_coef_addr),
        .o_load_coef  (o_load_coef),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_checksum   (o_checksum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    int cyc = 0;
    int s_edge = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [BW-1:0]   words [64];
    logic [AW-1:0]   q_addr [$];
    logic [2*BW-1:0] q_coef [$];
    int              q_rel  [$];
    int              done_cnt;
    int              done_rel;
    logic [BW-1:0]   chk_at_done;

    // Record write strobes and the done pulse away from the active edge.
    always @(negedge clk) begin
        if (o_load_coef) begin
            q_addr.push_back(o_coef_addr);
            q_coef.push_back(o_coef);
            q_rel.push_back(cyc - s_edge + 1);
        end
        if (o_done) begin
            done_cnt    = done_cnt + 1;
            done_rel    = cyc - s_edge + 1;
            chk_at_done = o_checksum;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        q_addr.delete();
        q_coef.delete();
        q_rel.delete();
        done_cnt = 0;
        done_rel = 0;
        chk_at_done = '0;
    endtask

    // Pulse start for one cycle; s_edge marks the edge that sampled it.
    task automatic start_load();
        @(posedge clk);
        #1 i_start = 1'b1;
        @(posedge clk);
        #1;
        s_edge  = cyc;
        i_start = 1'b0;
    endtask

    // Stream n words from words[]; optional stall, stray start pulse or reset at given word indices.
    task automatic send_words(input int n, input int stall_idx, input int stall_len,
                              input int start_idx, input int rst_idx);
        int idx;
        int guard;
        logic acc;
        idx = 0;
        guard = 0;
        i_coef_valid = 1'b1;
        i_coef_data  = words[0];
        while (idx < n && guard < 500) begin
            @(negedge clk);
            acc = o_coef_ready;
            @(posedge clk);
            #1;
            guard++;
            i_start = 1'b0;
            if (acc) begin
                idx++;
                if (idx == rst_idx) begin
                    rst = 1'b1;
                    #1;
                    check("rst_mid_ctl", {o_load_coef, o_coef_ready, o_busy, o_done}, 4'b0);
                    check("rst_mid_coef", o_coef, 32'h0);
                    check("rst_mid_addr", o_coef_addr, 4'h0);
                    check("rst_mid_csum", o_checksum, 16'h0);
                    i_coef_valid = 1'b0;
                    return;
                end
                if (idx == stall_idx) begin
                    i_coef_valid = 1'b0;
                    repeat (stall_len) begin
                        @(posedge clk);
                        #1;
                    end
                    check("stall_hold_rdy", {o_coef_ready, o_busy, o_load_coef}, 3'b110);
                    i_coef_valid = 1'b1;
                end
                if (idx == start_idx) i_start = 1'b1;
                if (idx < n) i_coef_data = words[idx];
            end
        end
        i_coef_valid = 1'b0;
        check("drv_budget", (guard < 500) ? 1 : 0, 1);
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        while (done_cnt == 0 && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("done_seen", done_cnt, 1);
    endtask

    // Compare every captured strobe against the pair built from words[].
    task automatic verify_table(input string tag);
        check({tag, "_nstrobe"}, q_addr.size(), NS);
        for (int i = 0; i < q_addr.size() && i < NS; i++) begin
            check({tag, "_addr"}, q_addr[i], i[AW-1:0]);
            check({tag, "_coef"}, q_coef[i], {words[2*i], words[2*i+1]});
        end
    endtask

    function automatic logic [BW-1:0] exp_csum(input logic [BW-1:0] s);
`ifdef NFU3_COEF_LOADER_CHECKSUM_EN
        return s;
`else
        return (s & 16'h0);
`endif
    endfunction

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        i_start = 1'b0;
        i_coef_data = '0;
        i_coef_valid = 1'b0;
        clear_mon();
        repeat (3) @(posedge clk);
        #1;
        check("reset_ctl", {o_load_coef, o_coef_ready, o_busy, o_done}, 4'b0);
        check("reset_coef", o_coef, 32'h0);
        check("reset_addr", o_coef_addr, 4'h0);
        check("reset_csum", o_checksum, 16'h0);
        rst = 1'b0;

        // Contiguous load of 1..32.
        for (int i = 0; i < 32; i++) words[i] = 16'(i + 1);
        clear_mon();
        start_load();
        check("t1_busy", o_busy, 1'b1);
        send_words(32, -1, 0, -1, -1);
        wait_done();
        verify_table("t1");
        check("t1_addr0", q_coef[0], 32'h0001_0002);
        check("t1_addr15", q_coef[15], 32'h001F_0020);
        check("t1_first_rel", q_rel[0], 3);
        check("t1_second_rel", q_rel[1], 6);
        check("t1_done_rel", done_rel, 49);
        check("t1_csum", chk_at_done, exp_csum(16'h0210));
        @(negedge clk);
        check("t1_idle_busy", {o_busy, o_done, o_coef_ready}, 3'b0);
        check("t1_hold_coef", o_coef, 32'h001F_0020);
        check("t1_hold_addr", o_coef_addr, 4'hF);

        // Stall of 5 cycles between ai3 and bi3.
        for (int i = 0; i < 32; i++) words[i] = 16'h1000 + 16'(i * 3);
        clear_mon();
        start_load();
        send_words(32, 7, 5, -1, -1);
        wait_done();
        verify_table("t2");
        check("t2_addr3", q_coef[3], 32'h1012_1015);
        check("t2_done_rel", done_rel, 54);

        // Stray start at segment 7 is ignored.
        for (int i = 0; i < 32; i++) words[i] = 16'hA000 ^ 16'(i * 257);
        clear_mon();
        start_load();
        send_words(32, -1, 0, 15, -1);
        wait_done();
        verify_table("t3");
        check("t3_done_rel", done_rel, 49);
        repeat (5) @(negedge clk);
        check("t3_no_restart", {o_busy, q_addr.size() == NS}, 2'b01);

        // Reset during segment 9 abandons the load.
        clear_mon();
        start_load();
        send_words(32, -1, 0, -1, 19);
        repeat (2) @(negedge clk);
        check("t4_strobes_before_rst", q_addr.size(), 9);
        check("t4_no_done", done_cnt, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 32; i++) words[i] = 16'h0100 + 16'(i);
        clear_mon();
        start_load();
        send_words(32, -1, 0, -1, -1);
        wait_done();
        verify_table("t4");
        check("t4_addr0", q_coef[0], 32'h0100_0101);

        // Checksum wrap with all-ones words.
        for (int i = 0; i < 32; i++) words[i] = 16'hFFFF;
        clear_mon();
        start_load();
        send_words(32, -1, 0, -1, -1);
        wait_done();
        check("t5_nstrobe", q_addr.size(), NS);
        check("t5_csum", chk_at_done, exp_csum(16'hFFE0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/nfu3_coef_loader.md
NFU3_COEF_LOADER -- requirements
Module: nfu3_coef_loader

Interface
REQ-001 Parameter BIT_WIDTH, default 16, width of one coefficient half (ai or bi).
REQ-002 Parameter NUM_SEG, default 16, number of piecewise-sigmoid segments loaded per table.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 i_start  input  1  one-cycle request to load a full coefficient table.
REQ-006 i_coef_data  input  BIT_WIDTH  streamed coefficient word; order ai0, bi0, ai1, bi1, ...
REQ-007 i_coef_valid  input  1  i_coef_data is valid.
REQ-008 o_coef_ready  output  1  loader accepts i_coef_data this cycle.
REQ-009 o_coef  output  2*BIT_WIDTH  packed RAM write line {ai, bi}; ai in the upper half.
REQ-010 o_coef_addr  output  log2(NUM_SEG)  segment write address.
REQ-011 o_load_coef  output  1  one-cycle RAM write strobe; drives the NFU-3 coefficient load input.
REQ-012 o_busy  output  1  a table load is in progress.
REQ-013 o_done  output  1  one-cycle pulse after the last segment is written.
REQ-014 o_checksum  output  BIT_WIDTH  sum of the table's accepted words (see Configuration).

Function
REQ-015 FSM states: IDLE, GET_A, GET_B, WRITE, DONE.
REQ-016 IDLE→GET_A on i_start=1; clear segment counter and checksum.
REQ-017 i_start outside IDLE is ignored; an in-progress load is never restarted.
REQ-018 o_coef_ready=1 only in GET_A and GET_B; a word is accepted when i_coef_valid & o_coef_ready.
REQ-019 GET_A: on accept, register word as ai and go to GET_B; otherwise hold.
REQ-020 GET_B: on accept, register word as bi and go to WRITE; otherwise hold.
REQ-021 WRITE lasts exactly one cycle: o_load_coef=1, o_coef={ai,bi}, o_coef_addr=segment counter.
REQ-022 After WRITE, if counter==NUM_SEG-1 go to DONE; else increment counter and go to GET_A.
REQ-023 DONE lasts one cycle with o_done=1, then returns to IDLE.
REQ-024 o_busy=1 in GET_A, GET_B and WRITE; 0 in IDLE and DONE.
REQ-025 Throughput with i_coef_valid held high: one write every 3 cycles.
REQ-026 Latency with i_coef_valid held high: first o_load_coef pulse 3 cycles after the edge sampling i_start; o_done pulse 3*NUM_SEG+1 cycles after that edge.
REQ-027 o_coef and o_coef_addr hold their last written values outside WRITE; consumers qualify them with o_load_coef only.
REQ-028 The segment counter never wraps within a load; it stops at NUM_SEG-1.

Reset
REQ-029 While rst=1: state=IDLE; counter, ai, bi, o_coef, o_coef_addr and o_checksum =0; o_load_coef, o_coef_ready, o_busy, o_done =0.
REQ-030 Reset asserted mid-load abandons the load immediately, with no partial write strobe; the next load restarts at segment 0.

Configuration
REQ-031 Macro NFU3_COEF_LOADER_CHECKSUM_EN defined: o_checksum accumulates every accepted word modulo 2^BIT_WIDTH, is cleared on start, and is final when o_done=1.
REQ-032 Macro not defined: no accumulator logic; o_checksum is tied to 0; the port list is unchanged.

Structure
REQ-033 Shared package nfu_pkg holds the FSM state encoding, the BIT_WIDTH default and the NUM_SEG default.
REQ-034 Single module; no sub-module. It instantiates directly alongside nfu_3.

Verification
REQ-035 Contiguous load: i_start, then 32 words 0x0001..0x0020 with valid held high → 16 strobes at addr 0..15; addr 0 has o_coef=0x00010002; addr 15 has 0x001F0020; o_done at cycle 49.
REQ-036 Stalls: drop i_coef_valid for 5 cycles between ai3 and bi3 → state holds in GET_B; addr 3 is written with the correct pair; o_done is delayed by 5 cycles.
REQ-037 i_start pulsed at segment 7 → ignored; the load completes with exactly 16 strobes.
REQ-038 rst pulsed at segment 9 → all outputs 0 at once; a new load then writes from addr 0.
REQ-039 Checksum enabled, words 0xFFFF ×32 → o_checksum=0xFFE0 at o_done; checksum disabled → o_checksum=0.
